// File: rtl/transceiver_pkg.sv
// Shared definitions for the transceiver serializer/deserializer pair.
package transceiver_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    // Bit-order encoding, shared with the PISO serializer.
    localparam bit ORDER_MSB_FIRST = 1'b0;
    localparam bit ORDER_LSB_FIRST = 1'b1;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/deserializer_sipo_shift_reg.sv
// Bit-level front end of the SIPO deserializer: shift register, bit counter
// and word-completion strobe with the finished word formed combinationally.
module sipo_shift_reg
    import transceiver_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit LSB_FIRST  = ORDER_LSB_FIRST
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  shift_i,
    input  logic                  srl_i,
    input  logic                  sync_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_done_o,
    output logic                  busy_o
);

    localparam int            CW   = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] shifted, restart;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        shifted = LSB_FIRST ? {srl_i, sr_q[DATA_WIDTH-1:1]} : {sr_q[DATA_WIDTH-2:0], srl_i};
        // A frame_sync bit lands in a cleared register, so no stale bits survive.
        restart = LSB_FIRST ? {srl_i, {(DATA_WIDTH-1){1'b0}}} : {{(DATA_WIDTH-1){1'b0}}, srl_i};
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (sync_i) begin
            sr_d  = shift_i ? restart : '0;
            cnt_d = shift_i ? CW'(1) : '0;
        end else if (shift_i) begin
            sr_d  = shifted;
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_o      = shifted;
    assign word_done_o = shift_i & ~sync_i & (cnt_q == LAST);
    assign busy_o      = (cnt_q != '0);

endmodule

// File: rtl/deserializer_sipo.sv
// SIPO deserializer top: word assembly plus a valid/ready output register
// with sticky overrun when a completed word cannot be delivered.
module deserializer_sipo
    import transceiver_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit LSB_FIRST  = ORDER_LSB_FIRST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  srl_in,
    input  logic                  shift,
    input  logic                  frame_sync,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  ovr_clr
);

    logic [DATA_WIDTH-1:0] word;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ovr_q;
    out_state_e            state_q;

    sipo_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shift (
        .clk_i       (clk),
        .rst_ni      (rst),
        .shift_i     (shift),
        .srl_i       (srl_in),
        .sync_i      (frame_sync),
        .word_o      (word),
        .word_done_o (word_done),
        .busy_o      (busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OUT_EMPTY;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (word_done) begin
                        data_q  <= word;
                        state_q <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    // A handshake in the completion cycle frees the slot for the new word.
                    if (word_done) begin
                        if (data_ready) data_q <= word;
                    end else if (data_ready) begin
                        state_q <= OUT_EMPTY;
                    end
                end
                default: state_q <= OUT_EMPTY;
            endcase

            if (state_q == OUT_FULL && word_done && !data_ready) ovr_q <= 1'b1;
            else if (ovr_clr)                                    ovr_q <= 1'b0;
        end
    end

    assign data_out   = data_q;
    assign data_valid = (state_q == OUT_FULL);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_deserializer_sipo.sv
// Scoreboard bench for deserializer_sipo: LSB-first and MSB-first instances
// share one bit stream; a monitor pops expected words on each handshake.
module tb_deserializer_sipo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       srl_in = 1'b0, shift = 1'b0, frame_sync = 1'b0;
    logic       data_ready = 1'b0, ovr_clr = 1'b0;
    logic [7:0] d_l, d_m;
    logic       v_l, v_m, b_l, b_m, o_l, o_m;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q_l[$];
    logic [7:0] q_m[$];

    always #5 clk = ~clk;

    deserializer_sipo #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .srl_in(srl_in), .shift(shift), .frame_sync(frame_sync),
        .data_out(d_l), .data_valid(v_l), .data_ready(data_ready),
        .busy(b_l), .overrun(o_l), .ovr_clr(ovr_clr)
    );

    deserializer_sipo #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .srl_in(srl_in), .shift(shift), .frame_sync(frame_sync),
        .data_out(d_m), .data_valid(v_m), .data_ready(data_ready),
        .busy(b_m), .overrun(o_m), .ovr_clr(ovr_clr)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic chk_both(input string n, input logic [7:0] dl, input logic [7:0] dm,
                            input logic v, input logic o, input logic b);
        chk({n, "_data_lsb"}, 32'(d_l), 32'(dl));
        chk({n, "_data_msb"}, 32'(d_m), 32'(dm));
        chk({n, "_valid"},    32'({v_l, v_m}), 32'({v, v}));
        chk({n, "_overrun"},  32'({o_l, o_m}), 32'({o, o}));
        chk({n, "_busy"},     32'({b_l, b_m}), 32'({b, b}));
    endtask

    // Monitor: a handshake happens at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rst) begin
            if (v_l && data_ready) begin
                if (q_l.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL lsb_extra_word: got 0x%0h expected no word", d_l);
                end else chk("lsb_word", 32'(d_l), 32'(q_l.pop_front()));
            end
            if (v_m && data_ready) begin
                if (q_m.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL msb_extra_word: got 0x%0h expected no word", d_m);
                end else chk("msb_word", 32'(d_m), 32'(q_m.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic b);
        shift  = 1'b1;
        srl_in = b;
        @(posedge clk); #1;
        shift  = 1'b0;
        srl_in = 1'b0;
    endtask

    // Bit v[0] is sent first.
    task automatic send_word(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] w;

        #12;
        chk_both("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;
        tick();

        // 1,0,1,0,0,1,0,1 -> A5 in either order; valid exactly one clk
        data_ready = 1'b1;
        q_l.push_back(8'hA5); q_m.push_back(8'hA5);
        w = 8'hA5;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        chk("t1_pre_valid", 32'({v_l, v_m}), 32'd0);
        chk("t1_busy", 32'({b_l, b_m}), 32'b11);
        send_bit(w[7]);
        chk_both("t1_done", 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t1_valid_one_clk", 32'({v_l, v_m}), 32'd0);

        // 1,1,0,0,0,0,0,0 -> 03 (LSB first) vs C0 (MSB first)
        q_l.push_back(8'h03); q_m.push_back(8'hC0);
        send_word(8'h03);
        chk_both("t2_done", 8'h03, 8'hC0, 1'b1, 1'b0, 1'b0);
        tick();

        // overrun: 3C held, F0 dropped
        data_ready = 1'b0;
        send_word(8'h3C);
        chk_both("t3_first", 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
        send_word(8'hF0);
        chk_both("t3_drop", 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("t3_ovr_clr", 32'({o_l, o_m}), 32'd0);
        q_l.push_back(8'h3C); q_m.push_back(8'h3C);
        data_ready = 1'b1;
        tick();
        chk_both("t3_drain", 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);

        // back-to-back 11 then 22, ready rises on 22's completion cycle
        data_ready = 1'b0;
        q_l.push_back(8'h11); q_m.push_back(8'h88);
        q_l.push_back(8'h22); q_m.push_back(8'h44);
        send_word(8'h11);
        chk_both("t4_first", 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);
        w = 8'h22;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        data_ready = 1'b1;
        send_bit(w[7]);
        chk_both("t4_swap", 8'h22, 8'h44, 1'b1, 1'b0, 1'b0);
        tick();
        chk_both("t4_drain", 8'h22, 8'h44, 1'b0, 1'b0, 1'b0);

        // frame_sync with a bit after 5 partial bits
        q_l.push_back(8'h01); q_m.push_back(8'h80);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        frame_sync = 1'b1;
        send_bit(1'b1);
        frame_sync = 1'b0;
        chk("t5_sync_busy", 32'({b_l, b_m}), 32'b11);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        chk_both("t5_done", 8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
        tick();
        chk_both("t5_after", 8'h01, 8'h80, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-word with a word pending
        data_ready = 1'b0;
        send_word(8'h5A);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk_both("t6_before", 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_both("t6_async", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        data_ready = 1'b1;
        tick();
        q_l.push_back(8'h96); q_m.push_back(8'h69);
        send_word(8'h96);
        chk_both("t6_new", 8'h96, 8'h69, 1'b1, 1'b0, 1'b0);
        tick();
        tick();

        chk("lsb_queue_empty", 32'(q_l.size()), 32'd0);
        chk("msb_queue_empty", 32'(q_m.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deserializer_sipo.md
Name: deserializer_sipo

Overview:
Serial-input, parallel-output (SIPO) deserializer. It is the receive-side counterpart of the transceiver's PISO serializer. It samples one serial bit per qualified clock, assembles DATA_WIDTH-bit words in a shift register with a bit counter, and presents completed words through a valid/ready output register. Overrun detection and frame alignment are included so the block can sit directly behind the transceiver line interface.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range 2..32.
LSB_FIRST, 1, 1 = first received bit lands in data_out[0] (matches serializer shift order); 0 = first bit lands in data_out[DATA_WIDTH-1].

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
srl_in  input  1  serial data bit, sampled only when shift=1
shift  input  1  bit strobe; one bit consumed per clk with shift=1
frame_sync  input  1  word alignment; discards the partial word and restarts the bit count
data_out  output  DATA_WIDTH  assembled word, stable while data_valid=1
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  downstream accepts the word when data_valid & data_ready
busy  output  1  partial word in progress (bit count != 0)
overrun  output  1  sticky; a completed word was dropped
ovr_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst=0, asynchronous): shift register=0, bit counter=0, data_out=0, data_valid=0, busy=0, overrun=0. Reset mid-word discards the partial word; after release, the next shift is bit 0.
- Bit counter is $clog2(DATA_WIDTH) bits wide, range 0..DATA_WIDTH-1, with explicit wrap to 0 after the last bit. Never rely on natural overflow.
- Bit sampling, shift=1:
  - LSB_FIRST=1: shift register shifts right; srl_in enters the MSB.
  - LSB_FIRST=0: shift register shifts left; srl_in enters the LSB.
  - Counter increments.
- Word completion: the cycle with shift=1 and counter=DATA_WIDTH-1. The full word, including that cycle's srl_in, is formed combinationally and offered to the output register. Counter returns to 0.
- Output register, two states (EMPTY, FULL):
  - EMPTY + completion: load data_out; data_valid=1 on the next cycle. Latency is 1 clk from the last bit strobe.
  - FULL + data_ready=1, no completion: data_valid=0 next cycle; data_out keeps its last value.
  - FULL + data_ready=1 + completion in the same cycle: load the new word; data_valid stays 1; no overrun.
  - FULL + data_ready=0 + completion: new word is dropped, data_out is unchanged, overrun=1 next cycle.
- frame_sync=1:
  - Partial word is discarded and the shift register is cleared.
  - If shift=1 in the same cycle, srl_in is taken as bit 0 of a new word (counter=1). Otherwise counter=0.
  - frame_sync has priority over completion: a frame_sync on the last-bit cycle produces no word.
  - frame_sync does not affect the output register or overrun.
- busy = (counter != 0), registered-equivalent (driven directly from the counter).
- overrun: set as above. Cleared by ovr_clr=1; if a set and ovr_clr occur in the same cycle, set wins.
- data_valid may be asserted indefinitely; data_out must not change while data_valid=1 and data_ready=0.
- shift gaps of any length between bits are legal; the counter holds during gaps.

Decomposition:
- Package transceiver_pkg holds:
  - localparams for default DATA_WIDTH and the LSB_FIRST encoding (shared with the serializer);
  - a function computing counter width;
  - enum for the output register state (OUT_EMPTY, OUT_FULL).
- One natural sub-module: sipo_shift_reg. It holds the shift register and bit counter, and outputs word_done and the assembled word. The top level owns the handshake and overrun logic.

Test Plan:
- Reset release, then 8 strobes with bits 1,0,1,0,0,1,0,1, LSB_FIRST=1, data_ready=1 -> data_out=0xA5, data_valid high exactly 1 clk, starting 1 clk after the 8th strobe; overrun=0.
- Same bit stream with LSB_FIRST=0 -> data_out=0xA5 reversed = 0xA5; repeat with bits 1,1,0,0,0,0,0,0 -> 0x03 (LSB_FIRST=1) vs 0xC0 (LSB_FIRST=0).
- data_ready=0; send 0x3C then 0xF0 -> data_out stays 0x3C, overrun=1 after the second word; pulse ovr_clr -> overrun=0; raise data_ready -> one 0x3C transfer, data_valid=0 afterwards.
- Back-to-back words 0x11, 0x22 with data_ready asserted exactly on the completion cycle of 0x22 -> data_out goes 0x11 to 0x22 with no overrun and no data_valid gap.
- Send 5 bits, assert frame_sync with shift=1 and srl_in=1, then 7 more bits of 0 -> data_out=0x01, busy low after the word, partial bits never appear.
- Assert rst (active-low) after 3 bits of a word and while data_valid=1 -> all outputs 0 immediately (asynchronous); the next 8 bits form a correct new word.
